// File: rtl/fdiv_seq_if.sv
// Handshake and operand/result bundle for the sequential FP divider fdiv_seq.
// The issue side (master) drives operands and start. The divider (slave) returns the result and flags.
interface fdiv_seq_if;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        start;
  logic        ready;
  logic        done;
  logic [31:0] y;
  logic        ovf;
  logic        zdiv;

  modport master (output x1, x2, start, input ready, done, y, ovf, zdiv);
  modport slave  (input x1, x2, start, output ready, done, y, ovf, zdiv);
endinterface

// File: rtl/fdiv_seq.sv
// Sequential single-precision divider: restoring radix-2 mantissa division, fixed 28-cycle latency.
// Optional macro FDIV_ROUND_EN selects round-to-nearest-even; default build truncates.
module fdiv_seq (
  input logic       clk,
  input logic       rstn,
  fdiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_e;

  state_e             state_q;
  logic [4:0]         cnt_q;
  logic               sign_q;
  logic               e1_zero_q, e2_zero_q;
  logic signed [9:0]  ye0_q;
  logic [23:0]        m2_q;
  logic [25:0]        rem_q;
  logic [25:0]        q_q;
  logic [31:0]        y_q;
  logic               ovf_q, zdiv_q, done_q, ready_q;

  // One restoring step: compare, conditionally subtract.
  logic               q_bit;
  logic [24:0]        rem_sub;

  // NOTE: every always_comb output is assigned at the top so no path leaves it unassigned (no latch).
  always_comb begin
    q_bit   = (rem_q >= {2'b00, m2_q});
    rem_sub = q_bit ? 25'(rem_q - {2'b00, m2_q}) : rem_q[24:0];
  end

  logic [22:0]        mant_raw;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  ye_norm, ye_fin;
  logic [31:0]        y_d;
  logic               ovf_d, zdiv_d;
`ifdef FDIV_ROUND_EN
  logic               rnd_bit, sticky;
`endif

  always_comb begin
    if (q_q[25]) begin
      mant_raw = q_q[24:2];
      ye_norm  = ye0_q;
    end else begin
      mant_raw = q_q[23:1];
      ye_norm  = ye0_q - 10'sd1;
    end
`ifdef FDIV_ROUND_EN
    rnd_bit  = q_q[25] ? q_q[1] : q_q[0];
    sticky   = (q_q[25] & q_q[0]) | (rem_q != '0);
    mant_rnd = {1'b0, mant_raw} + {23'd0, rnd_bit & (sticky | mant_raw[0])};
`else
    mant_rnd = {1'b0, mant_raw};
`endif
    // A rounding carry-out leaves the mantissa field at zero and bumps the exponent.
    ye_fin = ye_norm + $signed({9'd0, mant_rnd[23]});

    y_d    = {sign_q, ye_fin[7:0], mant_rnd[22:0]};
    ovf_d  = 1'b0;
    zdiv_d = 1'b0;
    if (e2_zero_q) begin
      zdiv_d = 1'b1;
      y_d    = {sign_q, 8'hFF, 23'd0};
    end else if (e1_zero_q) begin
      y_d    = {sign_q, 31'd0};
    end else if (ye_fin >= 10'sd255) begin
      ovf_d  = 1'b1;
      y_d    = {sign_q, 8'hFF, 23'd0};
    end else if (ye_fin <= 10'sd0) begin
      y_d    = {sign_q, 31'd0};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      e1_zero_q <= 1'b0;
      e2_zero_q <= 1'b0;
      ye0_q     <= '0;
      m2_q      <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
      zdiv_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q    <= bus.x1[31] ^ bus.x2[31];
            e1_zero_q <= (bus.x1[30:23] == 8'd0);
            e2_zero_q <= (bus.x2[30:23] == 8'd0);
            ye0_q     <= $signed({2'b00, bus.x1[30:23]}) - $signed({2'b00, bus.x2[30:23]})
                         + 10'sd127;
            m2_q      <= {1'b1, bus.x2[22:0]};
            rem_q     <= {2'b01, bus.x1[22:0]};
            q_q       <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            state_q   <= DIV;
          end
        end
        DIV: begin
          q_q   <= {q_q[24:0], q_bit};
          rem_q <= {rem_sub, 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd25) state_q <= NORM;
        end
        NORM: begin
          y_q     <= y_d;
          ovf_q   <= ovf_d;
          zdiv_q  <= zdiv_d;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.y     = y_q;
  assign bus.ovf   = ovf_q;
  assign bus.zdiv  = zdiv_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed self-checking bench for fdiv_seq: results, flags, latency, handshake and async reset abort.
// Expected values are hand-computed; FDIV_ROUND_EN selects the rounded 1/3 result.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rstn;

  fdiv_seq_if bus ();

  fdiv_seq dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FDIV_ROUND_EN
  localparam logic [31:0] EXP_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] EXP_THIRD = 32'h3EAAAAAA;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a start for one rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sync);
    if (sync) @(negedge clk);
    bus.x1    = a;
    bus.x2    = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts rising edges after the start edge until done, bounded at 40.
  task automatic wait_done(input int already, output int lat, output bit ready_ok,
                           output bit y_stable);
    logic [31:0] y0;
    y0       = bus.y;
    lat      = already;
    ready_ok = 1'b1;
    y_stable = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.ready !== 1'b0) ready_ok = 1'b0;
      if (bus.y !== y0) y_stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic [31:0] ey,
                              input logic eo, input logic ez);
    check({tag, "_lat"},  32'(lat),       32'd27);
    check({tag, "_done"}, 32'(bus.done),  32'd1);
    check({tag, "_rdy"},  32'(bus.ready), 32'd1);
    check({tag, "_y"},    bus.y,          ey);
    check({tag, "_ovf"},  32'(bus.ovf),   32'(eo));
    check({tag, "_zdiv"}, 32'(bus.zdiv),  32'(ez));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ey, input logic eo, input logic ez);
    int lat;
    bit rok, yst;
    issue(a, b, 1'b1);
    wait_done(0, lat, rok, yst);
    check({tag, "_busy_rdy"}, 32'(rok), 32'd1);
    check({tag, "_hold_y"},   32'(yst), 32'd1);
    check_result(tag, lat, ey, eo, ez);
  endtask

  // Watches for a stray done over n cycles.
  task automatic no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit rok, yst;

    rstn      = 1'b0;
    bus.x1    = '0;
    bus.x2    = '0;
    bus.start = 1'b0;
    #12;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_y",     bus.y,          32'h0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_zdiv",  32'(bus.zdiv),  32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run_op("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("done_pulse_width", 32'(bus.done), 32'd0);

    run_op("one_third", 32'h3F800000, 32'h40400000, EXP_THIRD,    1'b0, 1'b0);
    run_op("neg_half",  32'hBF800000, 32'h3F000000, 32'hC0000000, 1'b0, 1'b0);
    run_op("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0);
    run_op("zero_num",  32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, 1'b0);
    run_op("div_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);

    // Back-to-back: start raised in the done cycle itself.
    issue(32'h40C00000, 32'h40000000, 1'b0);
    wait_done(0, lat, rok, yst);
    check("b2b_hold_y", 32'(yst), 32'd1);
    check_result("b2b", lat, 32'h40400000, 1'b0, 1'b0);

    // A start pulsed mid-division must be ignored.
    issue(32'hBF800000, 32'h3F000000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    issue(32'h40C00000, 32'h40000000, 1'b1);
    wait_done(6, lat, rok, yst);
    check_result("mid_start", lat, 32'hC0000000, 1'b0, 1'b0);
    no_done("mid_start_no_extra", 35);

    // Reset abort at iteration 10, with a non-zero result and zdiv held beforehand.
    run_op("pre_abort", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1);
    issue(32'h40C00000, 32'h40000000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done",  32'(bus.done),  32'd0);
    check("abort_y",     bus.y,          32'h0);
    check("abort_zdiv",  32'(bus.zdiv),  32'd0);
    @(negedge clk);
    rstn = 1'b1;
    no_done("abort_no_done", 35);
    run_op("post_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fdiv_seq.md
# fdiv_seq

Sequential single-precision floating-point divider, the inverse-direction companion to the pipelined multiplier in the FPU. It computes y = x1 / x2 with a restoring radix-2 mantissa divider, one quotient bit per cycle, under a start/ready/done handshake. The fixed latency lets the issue logic schedule writeback without polling. Denormals flush to zero, and exponent overflow saturates to the same encodings as the multiplier.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- x1  input  32  dividend (IEEE-754 single); sampled only on an accepted start.
- x2  input  32  divisor; sampled only on an accepted start.
- start  input  1  request; accepted when start & ready at a rising edge.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when y/ovf/zdiv become valid.
- y  output  32  quotient; held from done until the next done.
- ovf  output  1  exponent overflow flag, held with y.
- zdiv  output  1  divide-by-zero flag, held with y.

## Operation
- States:
  - IDLE → DIV on accepted start; operands, sign, exponent and 24-bit mantissas {1,frac} are latched.
  - DIV runs 26 iterations, counter 0..25, then → NORM.
  - NORM takes 1 cycle, registers y/ovf/zdiv, pulses done, → IDLE.
- Start while not ready is ignored; no queueing.
- Sign: ys = x1[31] ^ x2[31].
- Exponent: 10-bit signed, ye0 = e1 - e2 + 127.
- Divider:
  - Remainder register 26 bits, initialised to m1.
  - Each iteration: if rem >= m2, set q bit and subtract; then shift rem left by 1.
  - Produces q[25:0], where q[25] has weight 2^0; the quotient lies in [0.5, 2).
- Normalisation:
  - If q[25]=1: mant = q[24:2], round bit = q[1], sticky = q[0] | (rem != 0), ye = ye0.
  - Else: mant = q[23:1], round bit = q[0], sticky = (rem != 0), ye = ye0 - 1.
- Special cases, checked in NORM in priority order:
  1. e2 == 0: zdiv=1, y = {ys, 8'hFF, 0}.
  2. e1 == 0: y = {ys, 0, 0}.
  3. ye >= 255 after rounding: ovf=1, y = {ys, 8'hFF, 0}.
  4. ye <= 0: y = {ys, 0, 0}, ovf=0.
- Inputs with exponent 255 get no NaN/Inf handling; they are processed numerically.
- ovf and zdiv are cleared on every NORM that does not set them.

## Timing
- Reset values: state IDLE, ready=1, done=0, y=0, ovf=0, zdiv=0, counter=0.
- Reset is asynchronous and aborts any operation in flight. No done is produced for the aborted request.
- Latency is fixed for every case, including specials:
  - start accepted at edge k; DIV occupies edges k+1..k+26; NORM at edge k+27.
  - done is high for exactly the cycle following edge k+27.
  - ready returns high in that same cycle, so a start in the done cycle is accepted at edge k+28.
- Throughput: one division per 28 cycles.
- y/ovf/zdiv change only at the NORM edge. They are stable while busy, showing the previous result.

## Configuration
- FDIV_ROUND_EN defined:
  - Round-to-nearest-even: increment mant if round & (sticky | mant[0]).
  - A mantissa carry-out sets mant=0 and ye+1; the overflow check is applied after rounding.
- FDIV_ROUND_EN undefined:
  - Truncation, with the round bit and sticky ignored.
  - Sticky and remainder-compare logic is not synthesised.
  - Matches the multiplier's truncating behaviour.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → y=0x40400000, ovf=0, zdiv=0. done exactly 28 cycles after the start edge; ready low for cycles 1..27.
- 0x3F800000 / 0x40400000 (1/3) → y=0x3EAAAAAB with FDIV_ROUND_EN, 0x3EAAAAAA without.
- 0xBF800000 / 0x3F000000 (-1/0.5) → y=0xC0000000. Next, 0x7F000000 / 0x3E800000 → y=0x7F800000, ovf=1.
- 0x3F800000 / 0x00000000 → y=0x7F800000, zdiv=1. 0x00000000 / 0x40A00000 → y=0x00000000, zdiv=0, ovf=0.
- Back-to-back: assert start in the done cycle with new operands → accepted; second done 28 cycles later. start pulsed mid-DIV → ignored, first result unchanged.
- Pull rstn low at DIV iteration 10 → ready=1, done=0, y=0 immediately. Release, issue 6.0/2.0 → 0x40400000 after 28 cycles.
